// File: rtl/router_pkg.sv
// Shared constants and helpers for the router input-side datapath.
package router_pkg;

  localparam int CHK_XOR    = 0;
  localparam int CHK_SUM    = 1;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 2;

  // An address whose low `width` bits are all ones selects no channel.
  function automatic logic addr_invalid(input logic [31:0] addr, input int width);
    logic [31:0] mask;
    mask = (32'h1 << width) - 32'h1;
    return (addr & mask) == mask;
  endfunction

endpackage

// File: rtl/router_hold_fifo.sv
// Small circular buffer that parks bytes accepted while the channel FIFO is full.
module router_hold_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             ovf_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, rd_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot, so a full buffer can still take a byte.
  assign do_push = push_i && (!full_o || do_pop);
  assign ovf_o   = push_i && full_o && !do_pop;
  assign data_o  = mem_q[rd_q];

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= next_ptr(wr_q);
      if (do_pop)  rd_q <= next_ptr(rd_q);
      if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
      else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/router_reg_gen.sv
// Router input datapath register: header latch, FIFO write path with hold buffer,
// running packet check, length counter and error/overflow flags.
module router_reg_gen
  import router_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int HOLD_DEPTH = 2,
  parameter int CHK_MODE   = CHK_XOR,
  parameter int LEN_W      = 6
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              pkt_valid,
  input  logic [DATA_W-1:0] data_in,
  input  logic              fifo_full,
  input  logic              detect_add,
  input  logic              lfd_state,
  input  logic              ld_state,
  input  logic              laf_state,
  input  logic              rst_int_reg,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              parity_done,
  output logic              low_pkt_valid,
  output logic              err,
  output logic              bad_addr,
  output logic              hold_empty,
  output logic              hold_full,
  output logic              ovf,
  output logic [LEN_W-1:0]  pkt_len
);

  logic [DATA_W-1:0] header_q, acc_q, acc_d, chk_q, dout_q, hold_data;
  logic              dout_valid_q, parity_done_q, chk_pend_q, err_q, bad_addr_q;
  logic              low_pkt_valid_q, ovf_q;
  logic [LEN_W-1:0]  pkt_len_q;
  logic              accept, pay_acc, chk_acc, pop, push, direct;
  logic              hdr_ok, hdr_bad, hold_ovf;

  function automatic logic [DATA_W-1:0] chk_op(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    if (CHK_MODE == CHK_SUM) return a + b;
    return a ^ b;
  endfunction

  always_comb begin
    // laf_state never raises ld_state, so it only drains the hold buffer.
    accept  = ld_state && (pkt_valid || !parity_done_q);
    pay_acc = accept && pkt_valid;
    chk_acc = accept && !pkt_valid;
    pop     = !lfd_state && !fifo_full && !hold_empty;
    direct  = !lfd_state && accept && !fifo_full && hold_empty;
    push    = accept && !direct;
    hdr_bad = detect_add && pkt_valid && addr_invalid(32'(data_in[ADDR_W-1:0]), ADDR_W);
    hdr_ok  = detect_add && pkt_valid && !hdr_bad;
    acc_d   = acc_q;
    if (detect_add)     acc_d = '0;
    else if (lfd_state) acc_d = chk_op(acc_q, header_q);
    else if (pay_acc)   acc_d = chk_op(acc_q, data_in);
  end

  router_hold_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (HOLD_DEPTH)
  ) u_hold (
    .clock   (clock),
    .resetn  (resetn),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (data_in),
    .data_o  (hold_data),
    .empty_o (hold_empty),
    .full_o  (hold_full),
    .ovf_o   (hold_ovf)
  );

  always_ff @(posedge clock) begin
    if (!resetn) begin
      header_q        <= '0;
      acc_q           <= '0;
      chk_q           <= '0;
      dout_q          <= '0;
      dout_valid_q    <= 1'b0;
      parity_done_q   <= 1'b0;
      chk_pend_q      <= 1'b0;
      err_q           <= 1'b0;
      bad_addr_q      <= 1'b0;
      low_pkt_valid_q <= 1'b0;
      ovf_q           <= 1'b0;
      pkt_len_q       <= '0;
    end else begin
      if (hdr_ok) header_q <= data_in;
      if (hdr_bad)         bad_addr_q <= 1'b1;
      else if (detect_add) bad_addr_q <= 1'b0;

      dout_valid_q <= lfd_state || pop || direct;
      if (lfd_state)   dout_q <= header_q;
      else if (pop)    dout_q <= hold_data;
      else if (direct) dout_q <= data_in;

      acc_q <= acc_d;

      // The compare runs one cycle after capture so acc_q is final.
      if (detect_add) begin
        parity_done_q <= 1'b0;
        chk_pend_q    <= 1'b0;
        err_q         <= 1'b0;
      end else begin
        chk_pend_q <= chk_acc;
        if (chk_acc) begin
          chk_q         <= data_in;
          parity_done_q <= 1'b1;
        end
        if (chk_pend_q) err_q <= (chk_q != acc_q);
      end

      if (detect_add)                     pkt_len_q <= '0;
      else if (pay_acc && pkt_len_q != '1) pkt_len_q <= pkt_len_q + 1'b1;

      if (rst_int_reg)                  low_pkt_valid_q <= 1'b0;
      else if (ld_state && !pkt_valid)  low_pkt_valid_q <= 1'b1;

      if (hold_ovf) ovf_q <= 1'b1;
    end
  end

  assign dout          = dout_q;
  assign dout_valid    = dout_valid_q;
  assign parity_done   = parity_done_q;
  assign low_pkt_valid = low_pkt_valid_q;
  assign err           = err_q;
  assign bad_addr      = bad_addr_q;
  assign ovf           = ovf_q;
  assign pkt_len       = pkt_len_q;

endmodule

// File: doc/router_reg_gen.md
Name: router_reg_gen

Overview:
Parametrised packet datapath register for the router input side, sitting between the input port and the per-channel FIFOs and driven by the router FSM state strobes.
- Latches the header, forwards header and payload to the FIFO write bus, and computes a running check over each packet.
- Compares the result against the trailing check word and reports errors.
- Absorbs FIFO back-pressure in a small hold buffer, so bytes accepted while the FIFO is full are not lost.
- Adds a selectable check mode, a payload length counter and a sticky overflow flag.

Parameters:
DATA_W, 8, data/check word width (>=4)
ADDR_W, 2, header address field width, header[ADDR_W-1:0]; the all-ones address is invalid
HOLD_DEPTH, 2, hold-buffer entries (1..4)
CHK_MODE, 0, 0 = XOR parity, 1 = modulo-2^DATA_W additive checksum
LEN_W, 6, payload length counter width

Ports:
clock  in  1  clock
resetn  in  1  synchronous reset, active-low
pkt_valid  in  1  packet byte valid from source
data_in  in  DATA_W  packet byte
fifo_full  in  1  selected FIFO full
detect_add  in  1  FSM: header on data_in
lfd_state  in  1  FSM: load first data (header)
ld_state  in  1  FSM: load data
laf_state  in  1  FSM: load after full
rst_int_reg  in  1  FSM: clear low_pkt_valid
dout  out  DATA_W  FIFO write data
dout_valid  out  1  FIFO write enable for dout
parity_done  out  1  check word captured
low_pkt_valid  out  1  pkt_valid fell while in ld_state
err  out  1  check mismatch
bad_addr  out  1  header carried an invalid address
hold_empty  out  1  hold buffer empty
hold_full  out  1  hold buffer full
ovf  out  1  sticky: byte dropped, hold buffer overflowed
pkt_len  out  LEN_W  payload bytes accepted, saturating

Behaviour:
- Reset: every output is 0 except hold_empty=1. Header, accumulator, check register and hold pointers/count are also cleared. Reset mid-packet discards everything, including hold contents.
- Header capture: when detect_add && pkt_valid && data_in[ADDR_W-1:0] != all-ones, the header is latched.
  - On the same condition with an all-ones address, the header is not latched and bad_addr <= 1.
  - detect_add clears bad_addr, parity_done, err, pkt_len and the accumulator. It does not clear ovf or the hold buffer.
- Accept: a byte is accepted when ld_state && (pkt_valid || !parity_done).
  - Payload byte: pkt_valid=1.
  - Check word: pkt_valid=0, first such cycle only.
- Output path (registered, 1-cycle latency):
  - lfd_state: dout <= header, dout_valid <= 1.
  - Otherwise, if !fifo_full && !hold_empty: pop the oldest entry to dout, dout_valid=1. An accepted byte in the same cycle is pushed to the tail, so order is preserved.
  - Otherwise, if accepted && !fifo_full && hold_empty: dout <= data_in, dout_valid=1.
  - Otherwise, if accepted && fifo_full: push to hold, dout_valid=0.
  - Otherwise dout holds its value and dout_valid=0.
- Overflow: a push with the hold buffer full and no pop in the same cycle drops the byte and sets ovf=1. ovf is cleared only by reset.
- Hold flags: hold_full and hold_empty reflect the count after the current edge. Simultaneous push and pop leaves the count unchanged.
- Check accumulation:
  - On lfd_state: acc <= acc op header.
  - On each accepted payload byte: acc <= acc op data_in.
  - op is XOR (CHK_MODE=0) or add, truncated to DATA_W (CHK_MODE=1).
- pkt_len: increments on each accepted payload byte and saturates at 2^LEN_W-1.
- Check word: on acceptance, the check register <= data_in and parity_done <= 1. One cycle later, err <= (check register != acc). err then holds until detect_add or reset.
- low_pkt_valid: set on ld_state && !pkt_valid; cleared by rst_int_reg (rst_int_reg wins if both occur).
- laf_state accepts no new bytes and only drains the hold buffer.

Decomposition:
- Package router_pkg holds:
  - CHK_XOR and CHK_SUM mode constants;
  - the default DATA_W and ADDR_W;
  - an invalid-address helper function.
- Sub-module router_hold_fifo holds the HOLD_DEPTH circular buffer: push, pop, empty, full and an overflow pulse.

Test Plan:
- XOR, no stall: header 8'h05, payload 8'hA3, check 8'hA6 -> dout sequence 05, A3, A6, then parity_done=1, err=0, pkt_len=1.
- CHK_MODE=1: header 8'h05, payload 8'hA3, check 8'hA8 -> err=0. The same packet with check 8'hA6 -> err=1 one cycle after parity_done, held until the next detect_add.
- Header 8'h07 (ADDR_W=2) with detect_add -> bad_addr=1, header register unchanged, and lfd_state outputs the previous header.
- fifo_full=1 for 2 accepted bytes 11, 22 (HOLD_DEPTH=2) -> hold_full=1, dout_valid=0. After fifo_full drops -> dout 11 then 22, hold_empty=1, ovf=0.
- fifo_full=1 for 3 accepted bytes 11, 22, 33 -> ovf=1, byte 33 dropped, drain yields only 11, 22. ovf stays 1 across the next detect_add.
- resetn=0 mid-packet with the hold buffer non-empty -> next cycle all outputs 0 and hold_empty=1. A following packet runs clean with err=0.
